sync_fifo_rd_stream: RTL and testbench

Read-side drain engine for the team's synchronous FIFO.
- Pops words through the FIFO's ren/empty/dout read port and re-presents them downstream as a valid/ready stream.
- Hides the FIFO's one-cycle read latency with a 3-entry prefetch buffer.
- Sustains one beat per cycle with no combinational path from m_ready to fifo_ren.
- Sits between the FIFO and any stream consumer, on the same clock.

---
 rtl/sync_fifo_rd_stream_pkg.sv | 15 +
 rtl/sync_fifo_rd_stream_if.sv | 32 +++
 rtl/sync_fifo_rd_stream_buf.sv | 46 ++++
 rtl/sync_fifo_rd_stream.sv | 84 ++++++++
 tb/tb_sync_fifo_rd_stream.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_rd_stream_pkg.sv
// Shared types and helpers for the synchronous FIFO read-side stream engine.
// Used by sync_fifo_rd_buf and sync_fifo_rd_stream.
package sync_fifo_pkg;

  localparam int BUF_DEPTH_C = 3;

  typedef logic [1:0] buf_ptr_t;
  typedef logic [1:0] occ_t;

  // Pointers cycle through 0,1,2 so the three entries behave as a ring.
  function automatic buf_ptr_t ptr_inc(input buf_ptr_t ptr);
    return (ptr == buf_ptr_t'(BUF_DEPTH_C - 1)) ? buf_ptr_t'(0) : ptr + buf_ptr_t'(1);
  endfunction

endpackage

// File: rtl/sync_fifo_rd_stream_if.sv
// Bundles the FIFO read port and the downstream valid/ready stream.
// The master modport is the drain engine's view; slave is the FIFO/consumer side.
interface sync_fifo_rd_stream_if #(
  parameter int WIDTH = 64
);

  logic             fifo_empty;
  logic             fifo_ren;
  logic [WIDTH-1:0] fifo_dout;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  m_ready,
    output fifo_ren,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    output m_ready,
    input  fifo_ren,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/sync_fifo_rd_stream_buf.sv
// Three-entry prefetch ring buffer: captures FIFO read data, presents the head word.
// The occupancy count lives here so capture and pop stay consistent in one place.
module sync_fifo_rd_buf
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output occ_t             occ,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [BUF_DEPTH_C];
  buf_ptr_t         wr_ptr;
  buf_ptr_t         rd_ptr;
  occ_t             occ_q;

  // Writes are never gated on occupancy: the issuing side reserved a slot already.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH_C; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd_en) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      occ_q <= occ_q + occ_t'(wr_en) - occ_t'(rd_en);
    end
  end

  assign occ     = occ_q;
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/sync_fifo_rd_stream.sv
// Drains the team's synchronous FIFO into a valid/ready stream at one beat per cycle.
// Optional macro SYNC_FIFO_RD_STREAM_BEATCNT_EN adds a 32-bit accepted-beat counter port.
module sync_fifo_rd_stream
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int BUF_DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  sync_fifo_rd_stream_if.master      bus
`ifdef SYNC_FIFO_RD_STREAM_BEATCNT_EN
  ,
  output logic [31:0]                beat_cnt
`endif
);

  generate
    if (BUF_DEPTH != BUF_DEPTH_C) begin : g_bad_depth
      $error("sync_fifo_rd_stream: BUF_DEPTH must be 3");
    end
  endgenerate

  logic       inflight;
  occ_t       occ;
  logic [2:0] committed;
  logic       issue;
  logic       pop;

  // A read is issued only if a slot is guaranteed for its data; m_ready is deliberately not used.
  assign committed    = {1'b0, occ} + {2'b00, inflight};
  assign issue        = reset && !bus.fifo_empty && (committed <= 3'd2);
  assign bus.fifo_ren = issue;

  assign bus.m_valid  = (occ != '0);
  assign pop          = bus.m_valid && bus.m_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
    end
  end

  sync_fifo_rd_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (inflight),
    .wr_data (bus.fifo_dout),
    .rd_en   (pop),
    .occ     (occ),
    .rd_data (bus.m_data)
  );

`ifdef SYNC_FIFO_RD_STREAM_BEATCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 32'd1;
    end
  end
`endif

  // A presented word must not change or vanish until the consumer takes it.
  a_hold_until_accepted : assert property (
    @(posedge clk) disable iff (!reset)
    (bus.m_valid && !bus.m_ready) |=> (bus.m_valid && $stable(bus.m_data))
  );

  a_never_overcommit : assert property (
    @(posedge clk) disable iff (!reset)
    committed <= 3'd3
  );

  a_no_pop_when_empty : assert property (
    @(posedge clk) disable iff (!reset)
    bus.fifo_ren |-> !bus.fifo_empty
  );

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Directed testbench for sync_fifo_rd_stream with a behavioural one-cycle-latency FIFO model.
// Define SYNC_FIFO_RD_STREAM_BEATCNT_EN to also check the beat counter.
module tb_sync_fifo_rd_stream;

  localparam int W = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  sync_fifo_rd_stream_if #(.WIDTH(W)) bus ();

`ifdef SYNC_FIFO_RD_STREAM_BEATCNT_EN
  logic [31:0] beat_cnt;
`endif

  sync_fifo_rd_stream #(
    .WIDTH     (W),
    .BUF_DEPTH (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef SYNC_FIFO_RD_STREAM_BEATCNT_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [W-1:0] fmem   [512];
  logic [W-1:0] rx_mem [256];
  int  wr_idx = 0;
  int  rd_idx = 0;
  bit  clear_on_reset = 1'b0;
  int  rx_cnt = 0;
  int  ren_cnt = 0;
  int  occ_track = 0;
  int  max_occ = 0;
  int  empty_pops = 0;
  bit  prev_ren = 1'b0;
  int  compared = 0;
  int  mismatched = 0;

  // FIFO model: registered empty flag, data one cycle after ren, garbage otherwise.
  initial begin
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = '0;
    forever begin
      @(posedge clk);
      if (!reset && clear_on_reset) begin
        rd_idx = wr_idx;
        bus.fifo_dout <= 64'hDEAD_BEEF_0BAD_F00D;
      end else if (bus.fifo_ren) begin
        if (rd_idx == wr_idx) begin
          empty_pops++;
        end else begin
          bus.fifo_dout <= fmem[rd_idx % 512];
          rd_idx++;
        end
      end else begin
        bus.fifo_dout <= 64'hDEAD_BEEF_0BAD_F00D;
      end
      bus.fifo_empty <= (rd_idx == wr_idx);
    end
  end

  // Stream monitor: logs accepted beats, counts reads, tracks buffer occupancy.
  always @(posedge clk) begin
    if (!reset) begin
      occ_track = 0;
    end else begin
      if (bus.fifo_ren) ren_cnt++;
      occ_track = occ_track + (prev_ren ? 1 : 0) - ((bus.m_valid && bus.m_ready) ? 1 : 0);
      if (bus.m_valid && bus.m_ready) begin
        rx_mem[rx_cnt % 256] = bus.m_data;
        rx_cnt++;
      end
      if (occ_track > max_occ) max_occ = occ_track;
    end
    prev_ren = reset && bus.fifo_ren;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic push(input logic [W-1:0] d);
    fmem[wr_idx % 512] = d;
    wr_idx++;
  endtask

  task automatic wait_ren(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.fifo_ren) found = 1'b1;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("[TB] FAIL %s: fifo_ren never rose got=0 exp=1", name);
    end
  endtask

  task automatic test_reset();
    int brx;
    reset = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    push(64'h99);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      compared += 3;
      if (bus.fifo_ren !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ren cyc=%0d got=%b exp=0", i, bus.fifo_ren); end
      if (bus.m_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid cyc=%0d got=%b exp=0", i, bus.m_valid); end
      if (bus.m_data !== '0) begin mismatched++; $display("[TB] FAIL reset_data cyc=%0d got=%h exp=0", i, bus.m_data); end
    end
`ifdef SYNC_FIFO_RD_STREAM_BEATCNT_EN
    compared++;
    if (beat_cnt !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
`endif
    reset = 1'b1;
    #1;
    compared++;
    if (bus.fifo_ren !== 1'b1) begin mismatched++; $display("[TB] FAIL release_ren got=%b exp=1", bus.fifo_ren); end
    brx = rx_cnt;
    bus.m_ready = 1'b1;
    repeat (6) @(negedge clk);
    compared += 3;
    if (rx_cnt - brx !== 1) begin mismatched++; $display("[TB] FAIL release_beats got=%0d exp=1", rx_cnt - brx); end
    if (rx_mem[brx % 256] !== 64'h99) begin mismatched++; $display("[TB] FAIL release_data got=%h exp=99", rx_mem[brx % 256]); end
    if (bus.m_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL release_idle got=%b exp=0", bus.m_valid); end
  endtask

  task automatic test_streaming();
    bus.m_ready = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 8; k++) push(64'(k));
    wait_ren("stream_first_ren");
    @(negedge clk);
    compared++;
    if (bus.m_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL stream_latency got=%b exp=0", bus.m_valid); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      compared += 2;
      if (bus.m_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stream_valid beat=%0d got=%b exp=1", k, bus.m_valid); end
      if (bus.m_data !== 64'(k)) begin mismatched++; $display("[TB] FAIL stream_data beat=%0d got=%h exp=%h", k, bus.m_data, 64'(k)); end
    end
    @(negedge clk);
    compared++;
    if (bus.m_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL stream_end got=%b exp=0", bus.m_valid); end
  endtask

  task automatic test_backpressure();
    int bren;
    bus.m_ready = 1'b0;
    @(negedge clk);
    bren = ren_cnt;
    for (int k = 0; k < 6; k++) push(64'hA + 64'(k));
    wait_ren("bp_first_ren");
    repeat (4) @(negedge clk);
    compared += 4;
    if (ren_cnt - bren !== 3) begin mismatched++; $display("[TB] FAIL bp_ren_count got=%0d exp=3", ren_cnt - bren); end
    if (bus.fifo_ren !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_ren_idle got=%b exp=0", bus.fifo_ren); end
    if (bus.m_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_valid got=%b exp=1", bus.m_valid); end
    if (bus.m_data !== 64'hA) begin mismatched++; $display("[TB] FAIL bp_head got=%h exp=a", bus.m_data); end
    repeat (3) @(negedge clk);
    compared += 2;
    if (ren_cnt - bren !== 3) begin mismatched++; $display("[TB] FAIL bp_ren_hold got=%0d exp=3", ren_cnt - bren); end
    if (bus.m_data !== 64'hA) begin mismatched++; $display("[TB] FAIL bp_head_stable got=%h exp=a", bus.m_data); end
    bus.m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      compared += 2;
      if (bus.m_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_drain_valid beat=%0d got=%b exp=1", k, bus.m_valid); end
      if (bus.m_data !== 64'hA + 64'(k)) begin mismatched++; $display("[TB] FAIL bp_drain_data beat=%0d got=%h exp=%h", k, bus.m_data, 64'hA + 64'(k)); end
    end
    @(negedge clk);
    compared++;
    if (bus.m_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_end got=%b exp=0", bus.m_valid); end
  endtask

  task automatic test_drain_empty();
    int bren;
    int brx;
    bus.m_ready = 1'b1;
    @(negedge clk);
    bren = ren_cnt;
    brx  = rx_cnt;
    push(64'h55);
    repeat (8) @(negedge clk);
    compared += 5;
    if (ren_cnt - bren !== 1) begin mismatched++; $display("[TB] FAIL drain_ren_count got=%0d exp=1", ren_cnt - bren); end
    if (rx_cnt - brx !== 1) begin mismatched++; $display("[TB] FAIL drain_beats got=%0d exp=1", rx_cnt - brx); end
    if (rx_mem[brx % 256] !== 64'h55) begin mismatched++; $display("[TB] FAIL drain_data got=%h exp=55", rx_mem[brx % 256]); end
    if (bus.m_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_idle got=%b exp=0", bus.m_valid); end
    if (empty_pops !== 0) begin mismatched++; $display("[TB] FAIL drain_empty_pops got=%0d exp=0", empty_pops); end
  endtask

  task automatic test_alternating();
    logic [W-1:0] exp_data [60];
    logic [W-1:0] held;
    bit           hold;
    int           brx;
    @(negedge clk);
    brx = rx_cnt;
    for (int i = 0; i < 60; i++) begin
      exp_data[i] = {$urandom, $urandom};
      push(exp_data[i]);
    end
    hold = 1'b0;
    held = '0;
    for (int c = 0; c < 600 && (rx_cnt - brx) < 60; c++) begin
      bus.m_ready = (c % 2) != 0;
      hold = bus.m_valid && !bus.m_ready;
      held = bus.m_data;
      @(negedge clk);
      if (hold) begin
        compared++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== held) begin
          mismatched++;
          $display("[TB] FAIL alt_hold cyc=%0d got=%b/%h exp=1/%h", c, bus.m_valid, bus.m_data, held);
        end
      end
    end
    compared += 3;
    if (rx_cnt - brx !== 60) begin mismatched++; $display("[TB] FAIL alt_beats got=%0d exp=60", rx_cnt - brx); end
    if (max_occ > 3) begin mismatched++; $display("[TB] FAIL alt_max_occ got=%0d exp<=3", max_occ); end
    if (empty_pops !== 0) begin mismatched++; $display("[TB] FAIL alt_empty_pops got=%0d exp=0", empty_pops); end
    for (int i = 0; i < 60; i++) begin
      compared++;
      if (rx_mem[(brx + i) % 256] !== exp_data[i]) begin
        mismatched++;
        $display("[TB] FAIL alt_data idx=%0d got=%h exp=%h", i, rx_mem[(brx + i) % 256], exp_data[i]);
      end
    end
    bus.m_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int brx;
    bus.m_ready = 1'b0;
    clear_on_reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) push(64'h100 + 64'(k));
    wait_ren("ar_first_ren");
    repeat (3) @(negedge clk);
    compared += 2;
    if (bus.m_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL ar_pre_valid got=%b exp=1", bus.m_valid); end
    if (bus.m_data !== 64'h100) begin mismatched++; $display("[TB] FAIL ar_pre_data got=%h exp=100", bus.m_data); end
    #2;
    reset = 1'b0;
    #1;
    compared += 3;
    if (bus.m_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL ar_valid_drop got=%b exp=0", bus.m_valid); end
    if (bus.fifo_ren !== 1'b0) begin mismatched++; $display("[TB] FAIL ar_ren_drop got=%b exp=0", bus.fifo_ren); end
    if (bus.m_data !== '0) begin mismatched++; $display("[TB] FAIL ar_data_clear got=%h exp=0", bus.m_data); end
`ifdef SYNC_FIFO_RD_STREAM_BEATCNT_EN
    compared++;
    if (beat_cnt !== 32'd0) begin mismatched++; $display("[TB] FAIL ar_beat_cnt_clear got=%0d exp=0", beat_cnt); end
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    brx = rx_cnt;
    bus.m_ready = 1'b1;
    push(64'h200);
    push(64'h201);
    repeat (8) @(negedge clk);
    compared += 4;
    if (rx_cnt - brx !== 2) begin mismatched++; $display("[TB] FAIL ar_beats got=%0d exp=2", rx_cnt - brx); end
    if (rx_mem[brx % 256] !== 64'h200) begin mismatched++; $display("[TB] FAIL ar_new_head got=%h exp=200", rx_mem[brx % 256]); end
    if (rx_mem[(brx + 1) % 256] !== 64'h201) begin mismatched++; $display("[TB] FAIL ar_second got=%h exp=201", rx_mem[(brx + 1) % 256]); end
    if (bus.m_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL ar_idle got=%b exp=0", bus.m_valid); end
`ifdef SYNC_FIFO_RD_STREAM_BEATCNT_EN
    compared++;
    if (beat_cnt !== 32'd2) begin mismatched++; $display("[TB] FAIL ar_beat_cnt got=%0d exp=2", beat_cnt); end
`endif
  endtask

  initial begin
    bus.m_ready = 1'b0;
    $display("[TB] starting sync_fifo_rd_stream bench");
    test_reset();
    test_streaming();
    test_backpressure();
    test_drain_empty();
    test_alternating();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
